// File: rtl/reg_file_rsp.sv
// reg_file_rsp: register file with two latency-programmable read handshake ports
// and one write handshake port.
`default_nettype none

module reg_file_rsp #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int NUM_REGS     = 32,
  parameter int RD_LATENCY   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REG_ADDR_LEN-1:0] Rd1_addr,
  input  logic                    Rd1_en,
  output logic [WIDTH-1:0]        Rd1_data,
  output logic                    Rd1_st,
  input  logic [REG_ADDR_LEN-1:0] Rd2_addr,
  input  logic                    Rd2_en,
  output logic [WIDTH-1:0]        Rd2_data,
  output logic                    Rd2_st,
  input  logic [REG_ADDR_LEN-1:0] Wr_addr,
  input  logic [WIDTH-1:0]        Wr_data,
  input  logic                    Wr_en,
  output logic                    Wr_st
);

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DONE} rd_state_t;
  typedef enum logic       {WR_IDLE, WR_DONE}          wr_state_t;

  // r0 and addresses beyond NUM_REGS are never stored and always read as zero.
  function automatic logic writable(input logic [REG_ADDR_LEN-1:0] a);
    return (a != '0) && (32'(a) < NUM_REGS);
  endfunction

  logic [WIDTH-1:0] regs [NUM_REGS];
  wr_state_t        wr_state;
  wr_state_t        wr_next;
  logic             wr_commit;

  always_comb begin
    wr_next   = wr_state;
    wr_commit = 1'b0;
    case (wr_state)
      WR_IDLE: if (Wr_en) begin
        wr_commit = 1'b1;
        wr_next   = WR_DONE;
      end
      WR_DONE: if (!Wr_en) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_state <= WR_IDLE;
    else        wr_state <= wr_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit && writable(Wr_addr)) begin
      regs[Wr_addr] <= Wr_data;
    end
  end

  assign Wr_st = (wr_state == WR_DONE);

  logic [REG_ADDR_LEN-1:0] rd_addr [2];
  logic [WIDTH-1:0]        rd_data [2];
  logic [1:0]              rd_en;
  logic [1:0]              rd_st;

  assign rd_addr[0] = Rd1_addr;
  assign rd_addr[1] = Rd2_addr;
  assign rd_en      = {Rd2_en, Rd1_en};
  assign Rd1_data   = rd_data[0];
  assign Rd2_data   = rd_data[1];
  assign Rd1_st     = rd_st[0];
  assign Rd2_st     = rd_st[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    rd_state_t               state;
    rd_state_t               next;
    logic [2:0]              cnt;
    logic [REG_ADDR_LEN-1:0] addr_q;
    logic [WIDTH-1:0]        data_q;
    logic [WIDTH-1:0]        rd_word;
    logic                    accept;
    logic                    capture;

    always_comb begin
      next    = state;
      accept  = 1'b0;
      capture = 1'b0;
      case (state)
        RD_IDLE: if (rd_en[p]) begin
          accept = 1'b1;
          next   = RD_WAIT;
        end
        RD_WAIT: begin
          if (!rd_en[p]) begin
            next = RD_IDLE;
          end else if (cnt == 3'd0) begin
            capture = 1'b1;
            next    = RD_DONE;
          end
        end
        RD_DONE: if (!rd_en[p]) next = RD_IDLE;
        default: next = RD_IDLE;
      endcase
    end

    // Forward a write landing on the capture edge so the strobe sees it.
    always_comb begin
      rd_word = '0;
      if (writable(addr_q)) begin
        if (wr_commit && (Wr_addr == addr_q)) rd_word = Wr_data;
        else                                  rd_word = regs[addr_q];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= RD_IDLE;
        cnt    <= '0;
        addr_q <= '0;
        data_q <= '0;
      end else begin
        state <= next;
        if (accept) begin
          addr_q <= rd_addr[p];
          cnt    <= 3'(RD_LATENCY - 1);
        end else if ((state == RD_WAIT) && (cnt != 3'd0)) begin
          cnt <= cnt - 3'd1;
        end
        if (capture) data_q <= rd_word;
      end
    end

    assign rd_data[p] = data_q;
    assign rd_st[p]   = (state == RD_DONE);
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_rsp.sv
// tb_reg_file_rsp: directed vector table plus hand sequences for latency,
// cancel and asynchronous reset behaviour of reg_file_rsp.
`default_nettype none

module tb_reg_file_rsp;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd1_addr, rd2_addr, wr_addr;
  logic        rd1_en, rd2_en, wr_en;
  logic [31:0] wr_data;

  logic [31:0] a_rd1_data, a_rd2_data, b_rd1_data, b_rd2_data;
  logic        a_rd1_st, a_rd2_st, a_wr_st, b_rd1_st, b_rd2_st, b_wr_st;

  int checks = 0;
  int errors = 0;

  reg_file_rsp #(.WIDTH(32), .REG_ADDR_LEN(5), .NUM_REGS(32), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rd1_addr(rd1_addr), .Rd1_en(rd1_en), .Rd1_data(a_rd1_data), .Rd1_st(a_rd1_st),
    .Rd2_addr(rd2_addr), .Rd2_en(rd2_en), .Rd2_data(a_rd2_data), .Rd2_st(a_rd2_st),
    .Wr_addr(wr_addr), .Wr_data(wr_data), .Wr_en(wr_en), .Wr_st(a_wr_st)
  );

  reg_file_rsp #(.WIDTH(32), .REG_ADDR_LEN(5), .NUM_REGS(32), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .Rd1_addr(rd1_addr), .Rd1_en(rd1_en), .Rd1_data(b_rd1_data), .Rd1_st(b_rd1_st),
    .Rd2_addr(rd2_addr), .Rd2_en(rd2_en), .Rd2_data(b_rd2_data), .Rd2_st(b_rd2_st),
    .Wr_addr(wr_addr), .Wr_data(wr_data), .Wr_en(wr_en), .Wr_st(b_wr_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        r1en;
    logic [4:0]  r1a;
    logic        r2en;
    logic [4:0]  r2a;
    logic        e_r1st;
    logic [31:0] e_r1d;
    logic        e_r2st;
    logic [31:0] e_r2d;
    logic        e_wst;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                              input logic r1en, input logic [4:0] r1a,
                              input logic r2en, input logic [4:0] r2a,
                              input logic e_r1st, input logic [31:0] e_r1d,
                              input logic e_r2st, input logic [31:0] e_r2d,
                              input logic e_wst);
    vec_t v;
    v.wen = wen; v.wa = wa; v.wd = wd; v.r1en = r1en; v.r1a = r1a;
    v.r2en = r2en; v.r2a = r2a; v.e_r1st = e_r1st; v.e_r1d = e_r1d;
    v.e_r2st = e_r2st; v.e_r2d = e_r2d; v.e_wst = e_wst;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1en, input logic [4:0] r1a,
                       input logic r2en, input logic [4:0] r2a);
    wr_en = wen; wr_addr = wa; wr_data = wd;
    rd1_en = r1en; rd1_addr = r1a; rd2_en = r2en; rd2_addr = r2a;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // write r5, read it back with a held strobe
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0,  0, 32'h0,        0, 0, 1);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0, 0, 0,  0, 32'h0,        0, 0, 0);
    vecs[2]  = mk(0, 0, 32'h0,        1, 5, 0, 0,  0, 32'h0,        0, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0,        1, 5, 0, 0,  1, 32'hDEADBEEF, 0, 0, 0);
    vecs[4]  = mk(0, 0, 32'h0,        1, 5, 0, 0,  1, 32'hDEADBEEF, 0, 0, 0);
    vecs[5]  = mk(0, 0, 32'h0,        0, 5, 0, 0,  0, 32'hDEADBEEF, 0, 0, 0);
    // dual read: r3 and r0 after attempted r0 write
    vecs[6]  = mk(1, 3, 32'h12345678, 0, 0, 0, 0,  0, 32'hDEADBEEF, 0, 0, 1);
    vecs[7]  = mk(0, 0, 32'h0,        0, 0, 0, 0,  0, 32'hDEADBEEF, 0, 0, 0);
    vecs[8]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0,  0, 32'hDEADBEEF, 0, 0, 1);
    vecs[9]  = mk(0, 0, 32'h0,        1, 3, 1, 0,  0, 32'hDEADBEEF, 0, 0, 0);
    vecs[10] = mk(0, 0, 32'h0,        1, 3, 1, 0,  1, 32'h12345678, 1, 0, 0);
    vecs[11] = mk(0, 0, 32'h0,        0, 0, 0, 0,  0, 32'h12345678, 0, 0, 0);
    // bypass on r9, then a later write must not disturb held data
    vecs[12] = mk(1, 9, 32'h1,        0, 0, 0, 0,  0, 32'h12345678, 0, 0, 1);
    vecs[13] = mk(0, 0, 32'h0,        1, 9, 0, 0,  0, 32'h12345678, 0, 0, 0);
    vecs[14] = mk(1, 9, 32'hA5A5A5A5, 1, 9, 0, 0,  1, 32'hA5A5A5A5, 0, 0, 1);
    vecs[15] = mk(0, 0, 32'h0,        1, 9, 0, 0,  1, 32'hA5A5A5A5, 0, 0, 0);
    vecs[16] = mk(1, 9, 32'h2,        1, 9, 0, 0,  1, 32'hA5A5A5A5, 0, 0, 1);
    vecs[17] = mk(0, 0, 32'h0,        0, 0, 0, 0,  0, 32'hA5A5A5A5, 0, 0, 0);
    vecs[18] = mk(0, 0, 32'h0,        1, 9, 0, 0,  0, 32'hA5A5A5A5, 0, 0, 0);
    vecs[19] = mk(0, 0, 32'h0,        1, 9, 0, 0,  1, 32'h2,        0, 0, 0);
    vecs[20] = mk(0, 0, 32'h0,        0, 0, 0, 0,  0, 32'h2,        0, 0, 0);
    // port-2 cancel at latency 1
    vecs[21] = mk(0, 0, 32'h0,        0, 0, 1, 3,  0, 32'h2,        0, 0, 0);
    vecs[22] = mk(0, 0, 32'h0,        0, 0, 0, 0,  0, 32'h2,        0, 0, 0);
    vecs[23] = mk(0, 0, 32'h0,        0, 0, 0, 0,  0, 32'h2,        0, 0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step;
    step;
    chk("reset rd1_st", 32'(a_rd1_st), 0);
    chk("reset rd2_st", 32'(a_rd2_st), 0);
    chk("reset wr_st", 32'(a_wr_st), 0);
    chk("reset rd1_data", a_rd1_data, 0);
    chk("reset rd2_data", a_rd2_data, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].wen, vecs[i].wa, vecs[i].wd, vecs[i].r1en, vecs[i].r1a,
            vecs[i].r2en, vecs[i].r2a);
      step;
      chk($sformatf("v%0d rd1_st", i), 32'(a_rd1_st), 32'(vecs[i].e_r1st));
      chk($sformatf("v%0d rd1_data", i), a_rd1_data, vecs[i].e_r1d);
      chk($sformatf("v%0d rd2_st", i), 32'(a_rd2_st), 32'(vecs[i].e_r2st));
      chk($sformatf("v%0d rd2_data", i), a_rd2_data, vecs[i].e_r2d);
      chk($sformatf("v%0d wr_st", i), 32'(a_wr_st), 32'(vecs[i].e_wst));
    end

    // latency 3: strobe three edges after acceptance
    drive(0, 0, 0, 1, 5, 0, 0);
    step; chk("lat3 N st", 32'(b_rd1_st), 0);
    step; chk("lat3 N+1 st", 32'(b_rd1_st), 0);
    step; chk("lat3 N+2 st", 32'(b_rd1_st), 0);
    step; chk("lat3 N+3 st", 32'(b_rd1_st), 1);
    chk("lat3 N+3 data", b_rd1_data, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 5, 0, 0);
    step; chk("lat3 release st", 32'(b_rd1_st), 0);

    // latency 3 cancel, then an immediate new request proves IDLE
    drive(0, 0, 0, 1, 3, 0, 0);
    step; chk("cancel N st", 32'(b_rd1_st), 0);
    drive(0, 0, 0, 0, 3, 0, 0);
    step; chk("cancel N+1 st", 32'(b_rd1_st), 0);
    drive(0, 0, 0, 1, 3, 0, 0);
    step; chk("cancel N+2 st", 32'(b_rd1_st), 0);
    chk("cancel data kept", b_rd1_data, 32'hDEADBEEF);
    step; chk("rereq N+3 st", 32'(b_rd1_st), 0);
    step; chk("rereq N+4 st", 32'(b_rd1_st), 0);
    step; chk("rereq N+5 st", 32'(b_rd1_st), 1);
    chk("rereq N+5 data", b_rd1_data, 32'h12345678);
    drive(0, 0, 0, 0, 0, 0, 0);
    step;

    // asynchronous reset while port 2 waits and the write is in DONE
    drive(1, 7, 32'hCAFEF00D, 0, 0, 1, 9);
    step;
    chk("pre-rst wr_st", 32'(a_wr_st), 1);
    chk("pre-rst rd2_st lat3", 32'(b_rd2_st), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst wr_st", 32'(a_wr_st), 0);
    chk("async rst wr_st lat3", 32'(b_wr_st), 0);
    chk("async rst rd1_data", a_rd1_data, 0);
    chk("async rst rd2_data", a_rd2_data, 0);
    chk("async rst rd2_st", 32'(a_rd2_st), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;

    drive(0, 0, 0, 1, 7, 1, 9);
    step;
    chk("post-rst accept st", 32'(a_rd1_st), 0);
    step;
    chk("post-rst r7 st", 32'(a_rd1_st), 1);
    chk("post-rst r7 data", a_rd1_data, 0);
    chk("post-rst r9 st", 32'(a_rd2_st), 1);
    chk("post-rst r9 data", a_rd2_data, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step;
    chk("post-rst release st", 32'(a_rd2_st), 0);
    drive(0, 0, 0, 1, 5, 0, 0);
    step;
    step;
    chk("post-rst r5 st", 32'(a_rd1_st), 1);
    chk("post-rst r5 cleared", a_rd1_data, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
